// File: rtl/s9234_n901_frame.sv
// Frame stage feeding the s9234 n901 cone: phase FSM, data chain, status/control
// registers and a start/done/ack result handshake. Optional history: S9234_N901_HIST_EN.
module s9234_n901_frame #(
  parameter int NSHIFT = 8
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       start,
  input  logic       ack,
  input  logic [7:0] din,
  input  logic [5:0] sin,
  input  logic [3:0] cin,
  input  logic       n901,
  output logic       g301,
  output logic       g306,
  output logic       g310,
  output logic       g314,
  output logic       g49,
  output logic       g54,
  output logic       g59,
  output logic       g64,
  output logic       g69,
  output logic       g74,
  output logic       g79,
  output logic       g84,
  output logic       g338,
  output logic       g341,
  output logic       g345,
  output logic       g349,
  output logic       g353,
  output logic       g357,
  output logic       g323,
  output logic       g332,
  output logic       g361,
  output logic       g374,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] hist
);

  // One-hot phase codes; all-zero is IDLE so the cone's zero decode means idle
  typedef enum logic [3:0] {
    IDLE  = 4'b0000,
    LOAD  = 4'b0001,
    SHIFT = 4'b0010,
    EVAL  = 4'b0100,
    DONE  = 4'b1000
  } phase_t;

  localparam logic [3:0] LAST = 4'(NSHIFT - 1);

  phase_t     phase;
  phase_t     phase_next;
  logic [7:0] d;
  logic [5:0] s;
  logic [3:0] c;
  logic [3:0] cnt;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) phase <= IDLE;
    else     phase <= phase_next;
  end

  // Unlisted codes fall through to the IDLE default
  always_comb begin
    phase_next = IDLE;
    case (phase)
      IDLE:  phase_next = start ? LOAD : IDLE;
      LOAD:  phase_next = SHIFT;
      SHIFT: phase_next = (cnt == LAST) ? EVAL : SHIFT;
      EVAL:  phase_next = DONE;
      DONE:  phase_next = ack ? IDLE : DONE;
      default: phase_next = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      d   <= '0;
      s   <= '0;
      c   <= '0;
      cnt <= '0;
    end else begin
      case (phase)
        LOAD: begin
          d   <= din;
          s   <= sin;
          c   <= cin;
          cnt <= '0;
        end
        SHIFT: begin
          d   <= {d[6:0], n901};
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef S9234_N901_HIST_EN
  logic [3:0] hist_q;

  // History survives across runs; only reset clears it
  always_ff @(posedge CK or posedge RST) begin
    if (RST)                hist_q <= '0;
    else if (phase == EVAL) hist_q <= {hist_q[2:0], n901};
  end

  assign hist = hist_q;
`else
  assign hist = 4'b0000;
`endif

  assign {g314, g310, g306, g301} = phase;
  assign {g84, g79, g74, g69, g64, g59, g54, g49} = d;
  assign {g357, g353, g349, g345, g341, g338} = s;
  assign {g374, g361, g332, g323} = c;

  assign busy   = (phase == LOAD) || (phase == SHIFT) || (phase == EVAL);
  assign done   = (phase == DONE);
  assign result = done ? d : 8'h00;

endmodule
